// File: rtl/pl_reset_pkg.sv
// pl_reset_pkg: shared definitions for the PL reset sequencer.
//   seq_state_e : sequencer state encoding (3 bits, visible on seq_state)
//   LOCK_CNT_W  : hold counter width, covers LOCK_HOLD_CYCLES up to LOCK_HOLD_MAX
//   DLY_CNT_W   : interconnect-to-peripheral delay counter width, covers
//                 INTC_TO_PERIPH up to DLY_MAX
package pl_reset_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_REL_INTC  = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_e;

  // Counters are sized for the largest supported setting so the package
  // stays independent of any one instance's parameters.
  localparam int LOCK_HOLD_MAX = 65536;
  localparam int DLY_MAX       = 256;
  localparam int LOCK_CNT_W    = $clog2(LOCK_HOLD_MAX);
  localparam int DLY_CNT_W     = $clog2(DLY_MAX);

endpackage

// File: rtl/pl_sync_bit.sv
// pl_sync_bit: STAGES-deep bit synchronizer, async-cleared to 0.
//   gclk   : destination clock
//   grst_n : async active-low clear
//   d      : asynchronous input bit
//   q      : synchronized output (last flop of the chain)
module pl_sync_bit #(
  parameter int STAGES = 3
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) ff <= '0;
    else         ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pl_reset_sequencer.sv
// pl_reset_sequencer: ordered reset release for the clk_wiz output domain.
//   pl_clk0              : domain clock
//   pl0_resetn           : async active-low reset from CIPS
//   dcm_locked           : clk_wiz lock, async
//   aux_reset_in         : async active-high external reset request
//   interconnect_aresetn : released first (active-low)
//   peripheral_aresetn   : released INTC_TO_PERIPH cycles later (active-low)
//   peripheral_reset     : active-high copy of peripheral reset
//   seq_done             : high in RUN only
//   seq_state            : current state encoding
//   lock_loss_count      : saturating count of lock losses after WAIT_LOCK
module pl_reset_sequencer
  import pl_reset_pkg::*;
#(
  parameter int SYNC_STAGES      = 3,
  parameter int LOCK_HOLD_CYCLES = 16,
  parameter int INTC_TO_PERIPH   = 4,
  parameter int AUX_MIN_PULSE    = 4,
  parameter int NUM_PERIPH       = 2
) (
  input  logic                  pl_clk0,
  input  logic                  pl0_resetn,
  input  logic                  dcm_locked,
  input  logic                  aux_reset_in,
  output logic                  interconnect_aresetn,
  output logic [NUM_PERIPH-1:0] peripheral_aresetn,
  output logic                  peripheral_reset,
  output logic                  seq_done,
  output logic [2:0]            seq_state,
  output logic [7:0]            lock_loss_count
);

  localparam int AUX_CNT_W = $clog2(AUX_MIN_PULSE + 1);

  // [0] reset release, [1] lock, [2] aux request
  logic [2:0] sync_d, sync_q;
  logic       rst_sync, locked_sync, aux_sync;

  assign sync_d = {aux_reset_in, dcm_locked, 1'b1};

  pl_sync_bit #(.STAGES(SYNC_STAGES)) u_sync [2:0] (
    .gclk   (pl_clk0),
    .grst_n (pl0_resetn),
    .d      (sync_d),
    .q      (sync_q)
  );

  assign rst_sync    = sync_q[0];
  assign locked_sync = sync_q[1];
  assign aux_sync    = sync_q[2];

  // Aux qualification: the count saturates at AUX_MIN_PULSE and clears
  // as soon as the synced request drops, so short pulses never qualify.
  logic [AUX_CNT_W-1:0] aux_cnt;
  logic                 aux_q;

  always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
    if (!pl0_resetn)                                aux_cnt <= '0;
    else if (!aux_sync)                             aux_cnt <= '0;
    else if (aux_cnt != AUX_CNT_W'(AUX_MIN_PULSE))  aux_cnt <= aux_cnt + 1'b1;
  end

  assign aux_q = (aux_cnt == AUX_CNT_W'(AUX_MIN_PULSE));

  seq_state_e            state, state_nxt;
  logic [LOCK_CNT_W-1:0] hold_cnt, hold_nxt;
  logic [DLY_CNT_W-1:0]  dly_cnt, dly_nxt;
  logic                  lost;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    dly_nxt   = dly_cnt;
    lost      = 1'b0;
    // aux wins over lock loss; a loss hidden behind aux is not counted
    if (aux_q) state_nxt = ST_RESET;
    else begin
      case (state)
        ST_RESET:     if (rst_sync) state_nxt = ST_WAIT_LOCK;
        ST_WAIT_LOCK: if (locked_sync) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
        end
        ST_HOLD: begin
          if (!locked_sync) begin
            lost      = 1'b1;
            state_nxt = ST_WAIT_LOCK;
          end else if (hold_cnt == LOCK_CNT_W'(LOCK_HOLD_CYCLES - 1)) begin
            state_nxt = ST_REL_INTC;
            dly_nxt   = '0;
          end else hold_nxt = hold_cnt + 1'b1;
        end
        ST_REL_INTC: begin
          if (!locked_sync) begin
            lost      = 1'b1;
            state_nxt = ST_WAIT_LOCK;
          end else if (dly_cnt == DLY_CNT_W'(INTC_TO_PERIPH - 1)) state_nxt = ST_RUN;
          else dly_nxt = dly_cnt + 1'b1;
        end
        ST_RUN: if (!locked_sync) begin
          lost      = 1'b1;
          state_nxt = ST_WAIT_LOCK;
        end
        default: state_nxt = ST_RESET;
      endcase
    end
  end

  // Reset outputs are decoded from the next state so they change on the
  // same edge as the state itself, glitch-free.
  always_ff @(posedge pl_clk0 or negedge pl0_resetn) begin
    if (!pl0_resetn) begin
      state                <= ST_RESET;
      hold_cnt             <= '0;
      dly_cnt              <= '0;
      interconnect_aresetn <= 1'b0;
      peripheral_aresetn   <= '0;
      peripheral_reset     <= 1'b1;
      seq_done             <= 1'b0;
      lock_loss_count      <= '0;
    end else begin
      state                <= state_nxt;
      hold_cnt             <= hold_nxt;
      dly_cnt              <= dly_nxt;
      interconnect_aresetn <= (state_nxt == ST_REL_INTC) || (state_nxt == ST_RUN);
      peripheral_aresetn   <= {NUM_PERIPH{state_nxt == ST_RUN}};
      peripheral_reset     <= (state_nxt != ST_RUN);
      seq_done             <= (state_nxt == ST_RUN);
      if (lost && lock_loss_count != 8'hFF) lock_loss_count <= lock_loss_count + 1'b1;
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_pl_reset_sequencer.sv
// tb_pl_reset_sequencer: directed scenarios with randomized timing, checked
// against expected state timelines derived from the release latencies.
module tb_pl_reset_sequencer;

  localparam int NP   = 2;
  localparam int HOLD = 16;
  localparam int DLY  = 4;

  logic          pl_clk0      = 1'b0;
  logic          pl0_resetn   = 1'b0;
  logic          dcm_locked   = 1'b1;
  logic          aux_reset_in = 1'b0;
  logic          interconnect_aresetn;
  logic [NP-1:0] peripheral_aresetn;
  logic          peripheral_reset;
  logic          seq_done;
  logic [2:0]    seq_state;
  logic [7:0]    lock_loss_count;

  int tests = 0;
  int fails = 0;

  always #5 pl_clk0 = ~pl_clk0;

  pl_reset_sequencer #(.NUM_PERIPH(NP)) dut (
    .pl_clk0              (pl_clk0),
    .pl0_resetn           (pl0_resetn),
    .dcm_locked           (dcm_locked),
    .aux_reset_in         (aux_reset_in),
    .interconnect_aresetn (interconnect_aresetn),
    .peripheral_aresetn   (peripheral_aresetn),
    .peripheral_reset     (peripheral_reset),
    .seq_done             (seq_done),
    .seq_state            (seq_state),
    .lock_loss_count      (lock_loss_count)
  );

  // Timeline of one episode, edges counted from the stimulus change:
  // before rst_at the previous state holds, then RESET until w, WAIT_LOCK
  // until h, then the fixed hold and delay windows, then RUN.
  function automatic logic [2:0] exp_st(int pre, int rst_at, int w, int h, int e);
    if (e < rst_at)         return 3'(pre);
    if (e < w)              return 3'd0;
    if (e < h)              return 3'd1;
    if (e < h + HOLD)       return 3'd2;
    if (e < h + HOLD + DLY) return 3'd3;
    return 3'd4;
  endfunction

  task automatic chk(string tag, logic [2:0] st, logic [7:0] llc);
    logic [15:0] obs, exp;
    obs = {interconnect_aresetn, peripheral_aresetn, peripheral_reset, seq_done,
           seq_state, lock_loss_count};
    exp = {(st == 3'd3) || (st == 3'd4), {NP{st == 3'd4}}, st != 3'd4, st == 3'd4,
           st, llc};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step edges e0..e1 of an episode, checking each just after the edge.
  task automatic win(string tag, int pre, int rst_at, int w, int h,
                     int e0, int e1, logic [7:0] l0, logic [7:0] l1);
    for (int e = e0; e <= e1; e++) begin
      @(posedge pl_clk0); #1;
      chk($sformatf("%s@%0d", tag, e), exp_st(pre, rst_at, w, h, e), (e >= w) ? l1 : l0);
    end
  endtask

  initial begin
    int d, g, l, p, q, r;

    // reset state
    repeat (10) @(posedge pl_clk0);
    #1 chk("reset", 3'd0, 8'd0);

    // power-up, lock stable: intc at edge 21, peripherals at edge 25
    pl0_resetn = 1'b1;
    win("pwr", 0, 4, 4, 5, 1, 30, 8'd0, 8'd0);

    // late lock
    pl0_resetn = 1'b0; dcm_locked = 1'b0;
    @(posedge pl_clk0); #1;
    chk("rst2", 3'd0, 8'd0);
    pl0_resetn = 1'b1;
    d = 50 + int'($urandom_range(0, 9));
    win("wait", 0, 4, 4, 1000, 1, d, 8'd0, 8'd0);
    dcm_locked = 1'b1;
    win("late", 1, 0, 0, 4, 1, 26, 8'd0, 8'd0);

    // one-cycle lock glitch part-way through HOLD
    pl0_resetn = 1'b0;
    @(posedge pl_clk0); #1;
    pl0_resetn = 1'b1;
    g = int'($urandom_range(0, 12));
    win("hold", 0, 4, 4, 5, 1, 5 + g, 8'd0, 8'd0);
    dcm_locked = 1'b0;
    win("glitch", 2, 4, 4, 5, 1, 1, 8'd0, 8'd1);
    dcm_locked = 1'b1;
    win("glitch", 2, 4, 4, 5, 2, 30, 8'd0, 8'd1);

    // lock loss in RUN
    l = int'($urandom_range(3, 8));
    dcm_locked = 1'b0;
    win("runloss", 4, 4, 4, l + 4, 1, l, 8'd1, 8'd2);
    dcm_locked = 1'b1;
    win("runloss", 4, 4, 4, l + 4, l + 1, l + 30, 8'd1, 8'd2);

    // short aux pulse is ignored
    p = int'($urandom_range(1, 3));
    aux_reset_in = 1'b1;
    win("auxs", 4, 1000, 1000, 1000, 1, p, 8'd2, 8'd2);
    aux_reset_in = 1'b0;
    win("auxs", 4, 1000, 1000, 1000, p + 1, 12, 8'd2, 8'd2);

    // long aux pulse forces RESET; restart after it drops, count unchanged
    q = int'($urandom_range(6, 10));
    aux_reset_in = 1'b1;
    win("auxl", 4, 8, q + 5, q + 6, 1, q, 8'd2, 8'd2);
    aux_reset_in = 1'b0;
    win("auxl", 4, 8, q + 5, q + 6, q + 1, q + 30, 8'd2, 8'd2);

    // reach REL_INTC via a RUN glitch, then pulse async reset there
    dcm_locked = 1'b0;
    win("rungl", 4, 4, 4, 5, 1, 1, 8'd2, 8'd3);
    dcm_locked = 1'b1;
    r = int'($urandom_range(0, 3));
    win("rungl", 4, 4, 4, 5, 2, 21 + r, 8'd2, 8'd3);
    pl0_resetn = 1'b0;
    #1 chk("async", 3'd0, 8'd0);
    #3 pl0_resetn = 1'b1;
    win("rerun", 0, 4, 4, 5, 1, 28, 8'd0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
